// File: rtl/exec_scoreboard.sv
// exec_scoreboard: golden-model checker for a PDP-8 style execution core.
// Tracks golden AC/L/PC on each retire, matches observed memory writes through
// a small FIFO (with same-cycle bypass) and compares DUT architectural state
// one cycle after every retire. Sticky error flags plus a saturating counter.
// Optional: define EXEC_CHK_STOP_ON_ERR_EN to freeze the checker on the first error.
module exec_scoreboard #(
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 12,
    parameter int WQ_DEPTH   = 4,
    parameter int ERR_W      = 8,
    parameter logic [ADDR_WIDTH-1:0] START_ADDR = 12'o200
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          retire,
    input  logic [2:0]                    op_sel,
    input  logic                          op_cla_cll,
    input  logic [ADDR_WIDTH-1:0]         ea,
    input  logic [DATA_WIDTH-1:0]         operand,
    input  logic [DATA_WIDTH-1:0]         dut_acc,
    input  logic                          dut_link,
    input  logic [ADDR_WIDTH-1:0]         dut_pc,
    input  logic                          wr_req,
    input  logic [ADDR_WIDTH-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    output logic                          err_acc,
    output logic                          err_link,
    output logic                          err_pc,
    output logic                          err_wr,
    output logic                          err_ovf,
    output logic [ERR_W-1:0]              err_cnt,
    output logic [$clog2(WQ_DEPTH):0]     wq_count,
    output logic                          halted
);

    localparam int PW = $clog2(WQ_DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = ADDR_WIDTH + DATA_WIDTH;

    typedef enum logic [2:0] {
        OP_AND, OP_TAD, OP_ISZ, OP_DCA, OP_JMS, OP_JMP, OP_IOT, OP_OPR
    } op_t;

    typedef enum logic [1:0] {
        IDLE,
        CHECK
`ifdef EXEC_CHK_STOP_ON_ERR_EN
        , HALT
`endif
    } state_t;

    state_t state, state_n;

    logic [DATA_WIDTH-1:0] gacc, gacc_n;
    logic                  glink, glink_n;
    logic [ADDR_WIDTH-1:0] gpc, gpc_n, gpc_inc;

    logic [EW-1:0]         wq_mem [WQ_DEPTH];
    logic [PW-1:0]         rd_ptr, wr_ptr;
    logic [EW-1:0]         wq_head;
    logic                  wq_empty, wq_full;

    logic                  run;
    logic                  wr_op;
    logic [DATA_WIDTH-1:0] exp_data;
    logic [DATA_WIDTH:0]   tad_sum;
    logic [DATA_WIDTH-1:0] isz_inc;
    logic                  push, pop, flush, push_ok;
    logic                  ev_acc, ev_link, ev_pc, ev_wr, ev_ovf, any_err;
    logic [2:0]            ev_n;
    logic [ERR_W:0]        cnt_sum;

`ifdef EXEC_CHK_STOP_ON_ERR_EN
    assign run = (state != HALT);
`else
    assign run = 1'b1;
    assign halted = 1'b0;
`endif

    // Golden next-state for the opcode retiring this cycle.
    always_comb begin
        gacc_n   = gacc;
        glink_n  = glink;
        gpc_inc  = gpc + ADDR_WIDTH'(1);
        gpc_n    = gpc_inc;
        exp_data = '0;
        wr_op    = 1'b0;
        tad_sum  = {1'b0, gacc} + {1'b0, operand};
        isz_inc  = operand + DATA_WIDTH'(1);
        unique case (op_t'(op_sel))
            OP_AND: gacc_n = gacc & operand;
            OP_TAD: begin
                gacc_n  = tad_sum[DATA_WIDTH-1:0];
                glink_n = glink ^ tad_sum[DATA_WIDTH];
            end
            OP_ISZ: begin
                wr_op    = 1'b1;
                exp_data = isz_inc;
                if (isz_inc == '0) gpc_n = gpc + ADDR_WIDTH'(2);
            end
            OP_DCA: begin
                wr_op    = 1'b1;
                exp_data = gacc;
                gacc_n   = '0;
            end
            OP_JMS: begin
                wr_op    = 1'b1;
                exp_data = DATA_WIDTH'(gpc_inc);
                gpc_n    = ea + ADDR_WIDTH'(1);
            end
            OP_JMP: gpc_n = ea;
            OP_OPR: begin
                if (op_cla_cll) begin
                    gacc_n  = '0;
                    glink_n = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Write matching, FIFO control and per-cycle error events.
    always_comb begin
        wq_empty = (wq_count == '0);
        wq_full  = (wq_count == CW'(WQ_DEPTH));
        wq_head  = wq_mem[rd_ptr];
        push     = 1'b0;
        pop      = 1'b0;
        flush    = 1'b0;
        ev_wr    = 1'b0;
        ev_ovf   = 1'b0;
        ev_acc   = 1'b0;
        ev_link  = 1'b0;
        ev_pc    = 1'b0;
        if (run) begin
            if (retire) begin
                if (wr_op) begin
                    // Oldest queued write is matched first; an empty queue lets
                    // a same-cycle write bypass straight to the compare.
                    if (!wq_empty) begin
                        pop   = 1'b1;
                        push  = wr_req;
                        ev_wr = (wq_head != {ea, exp_data});
                    end else if (wr_req) begin
                        ev_wr = ({wr_addr, wr_data} != {ea, exp_data});
                    end else begin
                        ev_wr = 1'b1;
                    end
                end else if (!wq_empty || wr_req) begin
                    ev_wr = 1'b1;
                    flush = 1'b1;
                end
            end else begin
                push = wr_req;
            end
            ev_ovf = push && wq_full && !pop;
            if (state == CHECK) begin
                ev_acc  = (dut_acc  != gacc);
                ev_link = (dut_link != glink);
                ev_pc   = (dut_pc   != gpc);
            end
        end
        push_ok = push && !ev_ovf;
        any_err = ev_acc | ev_link | ev_pc | ev_wr | ev_ovf;
        ev_n    = {2'b0, ev_acc} + {2'b0, ev_link} + {2'b0, ev_pc}
                + {2'b0, ev_wr} + {2'b0, ev_ovf};
        cnt_sum = {1'b0, err_cnt} + (ERR_W+1)'(ev_n);
    end

    // FSM next state: CHECK follows every retire; HALT absorbs on first error.
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    state_n = retire ? CHECK : IDLE;
            CHECK:   state_n = retire ? CHECK : IDLE;
`ifdef EXEC_CHK_STOP_ON_ERR_EN
            HALT:    state_n = HALT;
`endif
            default: state_n = IDLE;
        endcase
`ifdef EXEC_CHK_STOP_ON_ERR_EN
        if (any_err) state_n = HALT;
`endif
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_n;
    end

    // FIFO storage; contents are don't-care while pointers are reset.
    always_ff @(posedge clk) begin
        if (reset_n && push_ok) wq_mem[wr_ptr] <= {wr_addr, wr_data};
    end

    // Golden state, FIFO pointers, error flags and counter.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            gacc     <= '0;
            glink    <= 1'b0;
            gpc      <= START_ADDR;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            wq_count <= '0;
            err_acc  <= 1'b0;
            err_link <= 1'b0;
            err_pc   <= 1'b0;
            err_wr   <= 1'b0;
            err_ovf  <= 1'b0;
            err_cnt  <= '0;
        end else if (run) begin
            if (retire) begin
                gacc  <= gacc_n;
                glink <= glink_n;
                gpc   <= gpc_n;
            end
            if (flush) begin
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                wq_count <= '0;
            end else begin
                if (push_ok) wr_ptr <= wr_ptr + PW'(1);
                if (pop)     rd_ptr <= rd_ptr + PW'(1);
                if (push_ok && !pop)      wq_count <= wq_count + CW'(1);
                else if (!push_ok && pop) wq_count <= wq_count - CW'(1);
            end
            err_acc  <= err_acc  | ev_acc;
            err_link <= err_link | ev_link;
            err_pc   <= err_pc   | ev_pc;
            err_wr   <= err_wr   | ev_wr;
            err_ovf  <= err_ovf  | ev_ovf;
            err_cnt  <= cnt_sum[ERR_W] ? '1 : cnt_sum[ERR_W-1:0];
        end
    end

`ifdef EXEC_CHK_STOP_ON_ERR_EN
    // Registered halt indicator tracking entry into HALT.
    always_ff @(posedge clk) begin
        if (!reset_n) halted <= 1'b0;
        else          halted <= (state_n == HALT);
    end
`endif

endmodule

// File: tb/tb_exec_scoreboard.sv
// Directed testbench for exec_scoreboard (default parameters).
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_exec_scoreboard;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        retire = 1'b0;
    logic [2:0]  op_sel = '0;
    logic        op_cla_cll = 1'b0;
    logic [11:0] ea = '0;
    logic [11:0] operand = '0;
    logic [11:0] dut_acc = '0;
    logic        dut_link = 1'b0;
    logic [11:0] dut_pc = '0;
    logic        wr_req = 1'b0;
    logic [11:0] wr_addr = '0;
    logic [11:0] wr_data = '0;
    logic        err_acc, err_link, err_pc, err_wr, err_ovf;
    logic [7:0]  err_cnt;
    logic [2:0]  wq_count;
    logic        halted;

    int tests_run = 0;
    int tests_failed = 0;

    localparam logic [2:0] AND = 3'd0, TAD = 3'd1, ISZ = 3'd2, DCA = 3'd3,
                           JMS = 3'd4, JMP = 3'd5, IOT = 3'd6, OPR = 3'd7;

    exec_scoreboard #(
        .DATA_WIDTH(12), .ADDR_WIDTH(12), .WQ_DEPTH(4), .ERR_W(8),
        .START_ADDR(12'o200)
    ) dut (
        .clk(clk), .reset_n(reset_n), .retire(retire), .op_sel(op_sel),
        .op_cla_cll(op_cla_cll), .ea(ea), .operand(operand),
        .dut_acc(dut_acc), .dut_link(dut_link), .dut_pc(dut_pc),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .err_acc(err_acc), .err_link(err_link), .err_pc(err_pc),
        .err_wr(err_wr), .err_ovf(err_ovf), .err_cnt(err_cnt),
        .wq_count(wq_count), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        tests_run++;
        if (obs != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0o expected %0o", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset;
        reset_n = 1'b0;
        tick;
        tick;
        reset_n = 1'b1;
    endtask

    // Retire one instruction (any pre-set wr_req accompanies it), then an idle
    // cycle in which the DUT state given here is compared.
    task automatic retire_op(input logic [2:0] op, input logic cla,
                             input logic [11:0] e, input logic [11:0] opnd,
                             input logic [11:0] acc, input logic lnk,
                             input logic [11:0] pc);
        op_sel = op; op_cla_cll = cla; ea = e; operand = opnd;
        dut_acc = acc; dut_link = lnk; dut_pc = pc;
        retire = 1'b1;
        tick;
        retire = 1'b0;
        wr_req = 1'b0;
        tick;
    endtask

    task automatic push_wr(input logic [11:0] a, input logic [11:0] d);
        wr_req = 1'b1; wr_addr = a; wr_data = d;
        tick;
        wr_req = 1'b0;
    endtask

    function automatic logic [4:0] flags();
        return {err_acc, err_link, err_pc, err_wr, err_ovf};
    endfunction

    initial begin
        // Reset state
        do_reset;
        check_eq("rst_flags", flags(), 5'b00000);
        check_eq("rst_cnt", err_cnt, 0);
        check_eq("rst_wq", wq_count, 0);
        check_eq("rst_halt", halted, 0);

        // OPR CLA CLL then a clean TAD wrap into the link
        retire_op(OPR, 1'b1, 12'o0, 12'o0, 12'o0, 1'b0, 12'o201);
        check_eq("cla_flags", flags(), 5'b00000);
        check_eq("cla_cnt", err_cnt, 0);
        retire_op(TAD, 1'b0, 12'o0, 12'o7777, 12'o7777, 1'b0, 12'o202);
        retire_op(TAD, 1'b0, 12'o0, 12'o0001, 12'o0000, 1'b1, 12'o203);
        check_eq("tad_ok_flags", flags(), 5'b00000);
        check_eq("tad_ok_cnt", err_cnt, 0);

        // Same TAD, DUT reports link 0
        do_reset;
        retire_op(OPR, 1'b1, 12'o0, 12'o0, 12'o0, 1'b0, 12'o201);
        retire_op(TAD, 1'b0, 12'o0, 12'o7777, 12'o7777, 1'b0, 12'o202);
        retire_op(TAD, 1'b0, 12'o0, 12'o0001, 12'o0000, 1'b0, 12'o203);
        check_eq("tad_link_flags", flags(), 5'b01000);
        check_eq("tad_link_cnt", err_cnt, 1);

        // ISZ skip with bypassed write
        do_reset;
        wr_req = 1'b1; wr_addr = 12'o300; wr_data = 12'o0000;
        retire_op(ISZ, 1'b0, 12'o300, 12'o7777, 12'o0, 1'b0, 12'o202);
        check_eq("isz_flags", flags(), 5'b00000);
        check_eq("isz_wq", wq_count, 0);
        do_reset;
        wr_req = 1'b1; wr_addr = 12'o300; wr_data = 12'o0000;
        retire_op(ISZ, 1'b0, 12'o300, 12'o7777, 12'o0, 1'b0, 12'o201);
        check_eq("isz_pc_flags", flags(), 5'b00100);
        check_eq("isz_pc_cnt", err_cnt, 1);

        // JMS with missing write
        do_reset;
        retire_op(JMS, 1'b0, 12'o400, 12'o0, 12'o0, 1'b0, 12'o401);
        check_eq("jms_flags", flags(), 5'b00010);
        check_eq("jms_cnt", err_cnt, 1);

        // Overflow then spurious-write flush
        do_reset;
        for (int unsigned i = 0; i < 5; i++) push_wr(12'(12'o300 + i), 12'(i));
        check_eq("ovf_wq", wq_count, 4);
        check_eq("ovf_flags", flags(), 5'b00001);
        check_eq("ovf_cnt", err_cnt, 1);
        retire_op(AND, 1'b0, 12'o0, 12'o1234, 12'o0, 1'b0, 12'o201);
        check_eq("spur_flags", flags(), 5'b00011);
        check_eq("spur_wq", wq_count, 0);
        check_eq("spur_cnt", err_cnt, 2);

        // Full FIFO with simultaneous push and pop
        do_reset;
        for (int unsigned i = 0; i < 4; i++) push_wr(12'o300, 12'o0);
        wr_req = 1'b1; wr_addr = 12'o300; wr_data = 12'o0;
        retire_op(DCA, 1'b0, 12'o300, 12'o0, 12'o0, 1'b0, 12'o201);
        check_eq("pp_wq", wq_count, 4);
        check_eq("pp_flags", flags(), 5'b00000);

        // DCA via queue: match, then data mismatch; then JMP
        do_reset;
        retire_op(TAD, 1'b0, 12'o0, 12'o0005, 12'o0005, 1'b0, 12'o201);
        push_wr(12'o310, 12'o0005);
        check_eq("dca_wq1", wq_count, 1);
        retire_op(DCA, 1'b0, 12'o310, 12'o0, 12'o0, 1'b0, 12'o202);
        check_eq("dca_flags", flags(), 5'b00000);
        check_eq("dca_wq0", wq_count, 0);
        push_wr(12'o311, 12'o0001);
        retire_op(DCA, 1'b0, 12'o311, 12'o0, 12'o0, 1'b0, 12'o203);
        check_eq("dca_bad_flags", flags(), 5'b00010);
        retire_op(JMP, 1'b0, 12'o500, 12'o0, 12'o0, 1'b0, 12'o500);
        check_eq("jmp_flags", flags(), 5'b00010);
        check_eq("jmp_cnt", err_cnt, 1);

        // Spurious bypassed write on IOT
        do_reset;
        wr_req = 1'b1; wr_addr = 12'o300; wr_data = 12'o1;
        retire_op(IOT, 1'b0, 12'o0, 12'o0, 12'o0, 1'b0, 12'o201);
        check_eq("iot_flags", flags(), 5'b00010);
        check_eq("iot_wq", wq_count, 0);

        // Accumulator error; halt behaviour depends on build option
        do_reset;
        retire_op(OPR, 1'b0, 12'o0, 12'o0, 12'o0001, 1'b0, 12'o201);
        check_eq("acc_flags", flags(), 5'b10000);
        check_eq("acc_cnt", err_cnt, 1);
        retire_op(TAD, 1'b0, 12'o0, 12'o0001, 12'o0055, 1'b0, 12'o202);
`ifdef EXEC_CHK_STOP_ON_ERR_EN
        check_eq("halt_on", halted, 1);
        check_eq("halt_cnt", err_cnt, 1);
`else
        check_eq("halt_off", halted, 0);
        check_eq("cont_cnt", err_cnt, 2);
        check_eq("cont_flags", flags(), 5'b10000);
`endif

        // Counter saturation through repeated overflow
        do_reset;
        wr_req = 1'b1; wr_addr = 12'o300; wr_data = 12'o0;
        repeat (304) tick;
        wr_req = 1'b0;
`ifdef EXEC_CHK_STOP_ON_ERR_EN
        check_eq("sat_cnt", err_cnt, 1);
`else
        check_eq("sat_cnt", err_cnt, 8'hFF);
`endif
        check_eq("sat_wq", wq_count, 4);

        // Retire during reset is discarded
        retire = 1'b1; op_sel = JMP; ea = 12'o700;
        reset_n = 1'b0;
        tick;
        retire = 1'b0;
        tick;
        reset_n = 1'b1;
        check_eq("rst2_halt", halted, 0);
        retire_op(IOT, 1'b0, 12'o0, 12'o0, 12'o0, 1'b0, 12'o201);
        check_eq("rst2_flags", flags(), 5'b00000);
        check_eq("rst2_cnt", err_cnt, 0);
        check_eq("rst2_wq", wq_count, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/exec_scoreboard.md
EXEC_SCOREBOARD -- requirements
Module: exec_scoreboard

Interface
REQ-001 Parameter DATA_WIDTH, default 12, sets the data, accumulator and operand width.
REQ-002 Parameter ADDR_WIDTH, default 12, sets the address and PC width.
REQ-003 Parameter WQ_DEPTH, default 4 (power of 2, at least 2), sets the observed-write FIFO depth.
REQ-004 Parameter ERR_W, default 8, sets the error-counter width.
REQ-005 Parameter START_ADDR, default 12'o200, sets the golden PC reset value.
REQ-006 clk  in  1  free-running clock; single clock domain.
REQ-007 reset_n  in  1  reset, synchronous, active-low.
REQ-008 retire  in  1  one-cycle pulse; the DUT retired one instruction.
REQ-009 op_sel  in  3  retired opcode: 0 AND, 1 TAD, 2 ISZ, 3 DCA, 4 JMS, 5 JMP, 6 IOT, 7 OPR.
REQ-010 op_cla_cll  in  1  OPR instruction is CLA CLL; valid with retire.
REQ-011 ea  in  ADDR_WIDTH  effective address; valid with retire.
REQ-012 operand  in  DATA_WIDTH  C(EA) read by the DUT; valid with retire.
REQ-013 dut_acc, dut_link, dut_pc  in  DATA_WIDTH, 1, ADDR_WIDTH  DUT architectural state.
REQ-014 wr_req, wr_addr, wr_data  in  1, ADDR_WIDTH, DATA_WIDTH  DUT memory write, sampled when wr_req=1.
REQ-015 err_acc, err_link, err_pc, err_wr, err_ovf  out  1 each  sticky error flags.
REQ-016 err_cnt  out  ERR_W  total error count; saturates at all-ones.
REQ-017 wq_count  out  clog2(WQ_DEPTH)+1  FIFO occupancy.
REQ-018 halted  out  1  checker is frozen (only when the stop-on-error macro is defined).

Function
REQ-019 Golden state is gAcc (DATA_WIDTH), gLink and gPC; it updates only on a retire cycle.
REQ-020 Golden updates, with arithmetic modulo 2^width:
- AND: gAcc &= operand; gPC+1.
- TAD: {c,gAcc} = gAcc+operand; gLink ^= c; gPC+1.
- ISZ: expected write (ea, operand+1); gPC+2 if operand+1 wraps to 0, else gPC+1.
- DCA: expected write (ea, gAcc); gAcc=0; gPC+1.
- JMS: expected write (ea, gPC+1); gPC=ea+1.
- JMP: gPC=ea.
- OPR with op_cla_cll: gAcc=0; gLink=0; gPC+1.
- IOT or other OPR: gPC+1 only.
REQ-021 On every wr_req cycle, {wr_addr,wr_data} is pushed into the FIFO.
REQ-022 On retire of ISZ/DCA/JMS, the FIFO head is popped and compared with the expected write; a mismatch sets err_wr.
REQ-023 A write arriving in the same cycle as a retire is visible to that retire. With the FIFO empty, the write bypasses the FIFO and is compared directly.
REQ-024 Retire of ISZ/DCA/JMS with no write available sets err_wr (missing write).
REQ-025 Retire of any other opcode with wq_count>0 or wr_req=1 sets err_wr (spurious write) and flushes the FIFO.
REQ-026 A push into a full FIFO without a same-cycle pop drops the write and sets err_ovf. A push and pop in the same cycle leaves wq_count unchanged.
REQ-027 FSM states are IDLE, CHECK and HALT.
- IDLE to CHECK on retire.
- CHECK to CHECK on retire; otherwise CHECK to IDLE.
REQ-028 In CHECK, dut_acc, dut_link and dut_pc are compared with the updated golden values (one cycle after retire). Each mismatch sets its own flag.
REQ-029 err_cnt increments by the number of new error events in a cycle (0 to 5) and saturates.
REQ-030 All outputs are registered.

Reset
REQ-031 While reset_n=0 at a clk edge:
- gAcc=0, gLink=0, gPC=START_ADDR.
- FIFO empty, all err_* flags 0, err_cnt=0, halted=0, state IDLE.
REQ-032 Reset asserted mid-instruction discards pending compares and FIFO contents; the retire in that cycle is ignored.

Configuration
REQ-033 Macro EXEC_CHK_STOP_ON_ERR_EN is the single compile-time option.
REQ-034 When defined, the first cycle that sets any err_* flag moves the FSM to HALT. In HALT, halted=1, and golden state, FIFO, flags and err_cnt are frozen until reset.
REQ-035 When undefined, the HALT state does not exist, halted is tied to 0, and checking continues after errors.

Verification
REQ-036 Reset, then retire OPR CLA_CLL with dut_pc=0201 and dut_acc=0 -> no error flags, err_cnt=0.
REQ-037 Set gAcc=7777, retire TAD with operand 0001, DUT reports acc 0000, link 1 -> no errors. The same stimulus with the DUT reporting link 0 -> err_link=1, err_cnt=1.
REQ-038 DUT writes (0300, 0000) in the same cycle as retire ISZ with ea=0300 and operand=7777 -> write matches via bypass. gPC advances by 2; the DUT reporting PC+1 -> err_pc=1.
REQ-039 Retire JMS with ea=0400 at PC=0200 and no preceding write -> err_wr=1 (missing). The following compare requires dut_pc=0401.
REQ-040 WQ_DEPTH=4: push 5 writes with no retire -> wq_count=4, err_ovf=1. A subsequent retire of AND -> err_wr=1 and wq_count=0.
REQ-041 With EXEC_CHK_STOP_ON_ERR_EN defined, force err_acc -> halted=1 next cycle. Further retires leave err_cnt unchanged until reset_n=0.
